// File: rtl/mmu_pkg.sv
// Shared TLB entry layout, maintenance opcodes, segment codes and the translate helper.
// Purely declarative; no timing or flow control lives here.
package mmu_pkg;

  localparam int VPN2_W  = 19;
  localparam int ASID_W  = 8;
  localparam int PFN_W   = 20;
  localparam int CACHE_W = 3;
  localparam int HI_W    = VPN2_W + ASID_W;
  localparam int LO_W    = PFN_W + CACHE_W + 3;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
  } tlb_hi_t;

  typedef struct packed {
    logic [PFN_W-1:0]   pfn;
    logic [CACHE_W-1:0] c;
    logic               d;
    logic               v;
    logic               g;
  } tlb_lo_t;

  typedef struct packed {
    tlb_hi_t hi;
    tlb_lo_t lo0;
    tlb_lo_t lo1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    OP_TLBWI = 2'b00,
    OP_TLBWR = 2'b01,
    OP_TLBP  = 2'b10,
    OP_TLBR  = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } probe_state_e;

  localparam logic [2:0]         SEG_KSEG0  = 3'b100;
  localparam logic [2:0]         SEG_KSEG1  = 3'b101;
  localparam logic [CACHE_W-1:0] C_UNCACHED = 3'b010;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        uncached;
  } xlate_t;

  function automatic logic is_unmapped(input logic [2:0] seg);
    return (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
  endfunction

  // Store-dirty faults are layered on by the data channel; this covers the common path.
  function automatic xlate_t translate(input logic [31:0] vaddr, input logic hit,
                                       input tlb_lo_t lo);
    xlate_t x;
    x = '0;
    if (is_unmapped(vaddr[31:29])) begin
      x.paddr    = {3'b000, vaddr[28:0]};
      x.uncached = (vaddr[31:29] == SEG_KSEG1);
    end else if (!hit) begin
      x.miss = 1'b1;
    end else begin
      x.paddr    = {lo.pfn, vaddr[11:0]};
      x.uncached = (lo.c == C_UNCACHED);
      x.invalid  = !lo.v;
    end
    return x;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully associative TLB compare with lowest-index priority; returns the selected half.
// Combinational, zero latency, no flow control.
module tlb_match
  import mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 8
) (
  input  tlb_entry_t        entries [TLB_ENTRIES],
  input  logic [VPN2_W-1:0] vpn2,
  input  logic              odd,
  input  logic [ASID_W-1:0] asid,
  output logic              hit,
  output tlb_lo_t           lo
);

  // Walk from the top so the lowest matching index is the last assignment.
  always_comb begin
    hit = 1'b0;
    lo  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if ((entries[i].hi.vpn2 == vpn2) &&
          ((odd ? entries[i].lo1.g : entries[i].lo0.g) || (entries[i].hi.asid == asid))) begin
        hit = 1'b1;
        lo  = odd ? entries[i].lo1 : entries[i].lo0;
      end
    end
  end

endmodule

// File: rtl/mmu_tlb.sv
// Fetch/data address translation through a shared TLB, plus TLBWI/TLBWR/TLBP/TLBR maintenance.
// Lookups answer one cycle after request with no back-pressure; commands wait while tlb_busy.
module mmu_tlb
  import mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [31:0]       inst_vaddr,
  output logic              inst_valid,
  output logic [31:0]       inst_paddr,
  output logic              inst_miss,
  output logic              inst_invalid,
  output logic              inst_uncached,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [31:0]       data_vaddr,
  output logic              data_valid,
  output logic [31:0]       data_paddr,
  output logic              data_miss,
  output logic              data_invalid,
  output logic              data_modified,
  output logic              data_uncached,
  input  logic [ASID_W-1:0] asid,
  input  logic              tlb_op_valid,
  input  logic [1:0]        tlb_op,
  input  logic [IDX_W-1:0]  tlb_index,
  input  logic [IDX_W-1:0]  tlb_wired,
  input  logic [HI_W-1:0]   wr_hi,
  input  logic [LO_W-1:0]   wr_lo0,
  input  logic [LO_W-1:0]   wr_lo1,
  output logic              tlb_busy,
  output logic              tlb_done,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index,
  output logic [HI_W-1:0]   rd_hi,
  output logic [LO_W-1:0]   rd_lo0,
  output logic [LO_W-1:0]   rd_lo1
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [IDX_W:0]   NUM_ENT  = (IDX_W + 1)'(TLB_ENTRIES);

  tlb_entry_t       entries [TLB_ENTRIES];
  probe_state_e     state;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] random;
  tlb_hi_t          probe_hi;

  logic       i_hit, d_hit;
  tlb_lo_t    i_lo, d_lo;
  xlate_t     i_x, d_x;
  logic       d_mod;
  tlb_entry_t wr_entry;
  logic       scan_match;
  logic       op_accept;
  logic       idx_ok;

  tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_inst_match (
    .entries (entries),
    .vpn2    (inst_vaddr[31:13]),
    .odd     (inst_vaddr[12]),
    .asid    (asid),
    .hit     (i_hit),
    .lo      (i_lo)
  );

  tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_data_match (
    .entries (entries),
    .vpn2    (data_vaddr[31:13]),
    .odd     (data_vaddr[12]),
    .asid    (asid),
    .hit     (d_hit),
    .lo      (d_lo)
  );

  // Probe treats an entry as global only when both halves carry g.
  always_comb begin
    i_x        = translate(inst_vaddr, i_hit, i_lo);
    d_x        = translate(data_vaddr, d_hit, d_lo);
    d_mod      = data_wr && !is_unmapped(data_vaddr[31:29]) && d_hit && d_lo.v && !d_lo.d;
    wr_entry   = {wr_hi, wr_lo0, wr_lo1};
    scan_match = (entries[scan_idx].hi.vpn2 == probe_hi.vpn2) &&
                 ((entries[scan_idx].lo0.g && entries[scan_idx].lo1.g) ||
                  (entries[scan_idx].hi.asid == probe_hi.asid));
    op_accept  = tlb_op_valid && !tlb_busy;
    idx_ok     = {1'b0, tlb_index} < NUM_ENT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries[i] <= '0;
      state         <= S_IDLE;
      scan_idx      <= '0;
      probe_hi      <= '0;
      random        <= LAST_IDX;
      inst_valid    <= 1'b0;
      inst_paddr    <= '0;
      inst_miss     <= 1'b0;
      inst_invalid  <= 1'b0;
      inst_uncached <= 1'b0;
      data_valid    <= 1'b0;
      data_paddr    <= '0;
      data_miss     <= 1'b0;
      data_invalid  <= 1'b0;
      data_modified <= 1'b0;
      data_uncached <= 1'b0;
      tlb_busy      <= 1'b0;
      tlb_done      <= 1'b0;
      probe_hit     <= 1'b0;
      probe_index   <= '0;
      rd_hi         <= '0;
      rd_lo0        <= '0;
      rd_lo1        <= '0;
    end else begin
      inst_valid    <= inst_req;
      inst_miss     <= inst_req && i_x.miss;
      inst_invalid  <= inst_req && i_x.invalid;
      inst_uncached <= inst_req && i_x.uncached;
      if (inst_req) inst_paddr <= i_x.paddr;

      data_valid    <= data_req;
      data_miss     <= data_req && d_x.miss;
      data_invalid  <= data_req && d_x.invalid;
      data_modified <= data_req && d_mod;
      data_uncached <= data_req && d_x.uncached;
      if (data_req) data_paddr <= d_x.paddr;

      // Once random reaches (or sits below) the wired floor it restarts from the top.
      random   <= (random <= tlb_wired) ? LAST_IDX : random - IDX_W'(1);
      tlb_done <= 1'b0;

      if (op_accept) begin
        case (tlb_op_e'(tlb_op))
          OP_TLBWI: begin
            if (idx_ok) entries[tlb_index] <= wr_entry;
            tlb_done <= 1'b1;
          end
          OP_TLBWR: begin
            entries[random] <= wr_entry;
            tlb_done        <= 1'b1;
          end
          OP_TLBR: begin
            if (idx_ok) begin
              rd_hi  <= entries[tlb_index].hi;
              rd_lo0 <= entries[tlb_index].lo0;
              rd_lo1 <= entries[tlb_index].lo1;
            end
            tlb_done <= 1'b1;
          end
          default: begin
            state    <= S_SCAN;
            tlb_busy <= 1'b1;
            scan_idx <= '0;
            probe_hi <= wr_hi;
          end
        endcase
      end

      case (state)
        S_SCAN: begin
          if (scan_match || scan_idx == LAST_IDX) begin
            probe_hit   <= scan_match;
            probe_index <= scan_match ? scan_idx : '0;
            tlb_done    <= 1'b1;
            state       <= S_DONE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          tlb_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
